thor2022_reb_tracker: RTL

//  Owns reorder-buffer entry state and sequence numbers, driving the status vectors the scheduler picks from.

---
 rtl/thor2022_reb_tracker_pkg.sv | 30 +++
 rtl/thor2022_reb_min_sns.sv | 38 +++
 rtl/thor2022_reb_tracker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/thor2022_reb_tracker_pkg.sv
// ============================================================================
//  thor2022_reb_tracker_pkg
//  Shared types and constants for the reorder-buffer entry tracker.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package thor2022_reb_tracker_pkg;

  localparam int         REB_ENTRIES = 6;
  localparam logic [2:0] NONE_IDX    = 3'd7;

  typedef enum logic [2:0] {
    EMPTY        = 3'd0,
    FETCHED      = 3'd1,
    DECOMPRESSED = 3'd2,
    DECODED      = 3'd3,
    EXECUTED     = 3'd4
  } reb_state_t;

  function automatic logic [3:0] count_ones(input logic [7:0] vec);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(vec[i]);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/thor2022_reb_min_sns.sv
// ============================================================================
//  thor2022_reb_min_sns
//  Finds the smallest sequence number (and its entry) among valid, non-excluded entries.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module thor2022_reb_min_sns
  import thor2022_reb_tracker_pkg::*;
#(
  parameter int N     = REB_ENTRIES,
  parameter int SNS_W = 8
) (
  input  logic [N-1:0]       valid,
  input  logic [N-1:0]       excl,
  input  logic [N*SNS_W-1:0] sns,
  output logic               found,
  output logic [SNS_W-1:0]   min_sns,
  output logic [2:0]         min_idx
);

  // Strict less-than keeps the lowest index on ties (sns are unique in practice).
  always_comb begin
    found   = 1'b0;
    min_sns = '1;
    min_idx = NONE_IDX;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && !excl[i] && (!found || (sns[i*SNS_W +: SNS_W] < min_sns))) begin
        found   = 1'b1;
        min_sns = sns[i*SNS_W +: SNS_W];
        min_idx = 3'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/thor2022_reb_tracker.sv
// ============================================================================
//  thor2022_reb_tracker
//  Reorder-buffer entry FSMs, sequence numbers and in-order retire.
//  Optional REB_STATS_EN adds retire_total / stomp_total counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module thor2022_reb_tracker
  import thor2022_reb_tracker_pkg::*;
#(
  parameter int N     = REB_ENTRIES,
  parameter int SNS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         alloc0_idx,
  input  logic [2:0]         alloc1_idx,
  output logic               alloc_rdy,
  output logic               alloc_err,
  input  logic [2:0]         dcmp_idx,
  input  logic [2:0]         dec_idx,
  input  logic [2:0]         exec_idx,
  input  logic [2:0]         retire0_idx,
  input  logic [2:0]         retire1_idx,
  input  logic [N-1:0]       stomp,
  output logic [N-1:0]       v_o,
  output logic [N-1:0]       fetched_o,
  output logic [N-1:0]       decompressed_o,
  output logic [N-1:0]       decoded_o,
  output logic [N-1:0]       executed_o,
  output logic [N*SNS_W-1:0] sns_o,
`ifdef REB_STATS_EN
  output logic [31:0]        retire_total,
  output logic [31:0]        stomp_total,
`endif
  output logic [1:0]         retire_cnt
);

  localparam logic [SNS_W-1:0] C_RENORM_TH = SNS_W'((1 << SNS_W) - 2);

  reb_state_t       r_state [N];
  logic [SNS_W-1:0] r_sns   [N];
  logic [SNS_W-1:0] r_cnt;
  logic             r_alloc_err;
  logic [1:0]       r_retire_cnt;

  logic [N-1:0] w_valid, w_executed;
  logic [N-1:0] w_sel_a0, w_sel_a1, w_sel_dcmp, w_sel_dec, w_sel_exec, w_sel_r0, w_sel_r1;
  logic [N-1:0] w_ret;
  logic         w_alloc_rdy, w_renorm, w_a0_acc, w_a1_acc, w_alloc_err_nxt;
  logic         w_r0_acc, w_r1_acc;

  logic             w_min_found, w_min1_found;
  logic [SNS_W-1:0] w_min_sns, w_min1_sns;
  logic [2:0]       w_min_idx, w_min1_idx;
  logic             w_unused;

  for (genvar i = 0; i < N; i++) begin : g_entry
    assign w_valid[i]        = (r_state[i] != EMPTY);
    assign w_executed[i]     = (r_state[i] == EXECUTED);
    assign fetched_o[i]      = (r_state[i] == FETCHED);
    assign decompressed_o[i] = (r_state[i] == DECOMPRESSED);
    assign decoded_o[i]      = (r_state[i] == DECODED);
    assign sns_o[i*SNS_W +: SNS_W] = r_sns[i];
  end

  assign v_o        = w_valid;
  assign executed_o = w_executed;
  assign alloc_rdy  = w_alloc_rdy;
  assign alloc_err  = r_alloc_err;
  assign retire_cnt = r_retire_cnt;

  thor2022_reb_min_sns #(.N(N), .SNS_W(SNS_W)) u_min_all (
    .valid   (w_valid),
    .excl    ({N{1'b0}}),
    .sns     (sns_o),
    .found   (w_min_found),
    .min_sns (w_min_sns),
    .min_idx (w_min_idx)
  );

  thor2022_reb_min_sns #(.N(N), .SNS_W(SNS_W)) u_min_rest (
    .valid   (w_valid),
    .excl    (w_sel_r0),
    .sns     (sns_o),
    .found   (w_min1_found),
    .min_sns (w_min1_sns),
    .min_idx (w_min1_idx)
  );

  assign w_unused = ^w_min1_sns;

  // Index 7 (and anything >= N) never matches an entry, so "none" falls out naturally.
  always_comb begin
    w_sel_a0   = '0;
    w_sel_a1   = '0;
    w_sel_dcmp = '0;
    w_sel_dec  = '0;
    w_sel_exec = '0;
    w_sel_r0   = '0;
    w_sel_r1   = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_a0[i]   = (alloc0_idx == 3'(i));
      w_sel_a1[i]   = (alloc1_idx == 3'(i)) && (alloc1_idx != alloc0_idx);
      w_sel_dcmp[i] = (dcmp_idx == 3'(i));
      w_sel_dec[i]  = (dec_idx == 3'(i));
      w_sel_exec[i] = (exec_idx == 3'(i));
      w_sel_r0[i]   = (retire0_idx == 3'(i));
      w_sel_r1[i]   = (retire1_idx == 3'(i));
    end

    w_alloc_rdy     = (r_cnt < C_RENORM_TH);
    w_renorm        = !w_alloc_rdy;
    w_a0_acc        = w_alloc_rdy && |(w_sel_a0 & ~w_valid & ~stomp);
    w_a1_acc        = w_alloc_rdy && |(w_sel_a1 & ~w_valid & ~stomp);
    w_alloc_err_nxt = |(w_sel_a0 & w_valid) || |(w_sel_a1 & w_valid);

    w_r0_acc = |(w_sel_r0 & w_executed & ~stomp) && w_min_found && (w_min_idx == retire0_idx);
    w_r1_acc = w_r0_acc && (retire1_idx != retire0_idx) && |(w_sel_r1 & w_executed & ~stomp)
               && w_min1_found && (w_min1_idx == retire1_idx);
    w_ret    = (w_sel_r0 & {N{w_r0_acc}}) | (w_sel_r1 & {N{w_r1_acc}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= EMPTY;
        r_sns[i]   <= '0;
      end
      r_cnt        <= '0;
      r_alloc_err  <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_alloc_err  <= w_alloc_err_nxt;
      r_retire_cnt <= {1'b0, w_r0_acc} + {1'b0, w_r1_acc};

      // No allocation is accepted while renormalising, so cnt only shrinks here.
      if (w_renorm) r_cnt <= w_min_found ? (r_cnt - w_min_sns) : '0;
      else          r_cnt <= r_cnt + SNS_W'(w_a0_acc) + SNS_W'(w_a1_acc);

      for (int i = 0; i < N; i++) begin
        if (stomp[i]) begin
          r_state[i] <= EMPTY;
        end else begin
          case (r_state[i])
            EMPTY:        if ((w_sel_a0[i] && w_a0_acc) || (w_sel_a1[i] && w_a1_acc))
                            r_state[i] <= FETCHED;
            FETCHED:      if (w_sel_dcmp[i]) r_state[i] <= DECOMPRESSED;
            DECOMPRESSED: if (w_sel_dec[i])  r_state[i] <= DECODED;
            DECODED:      if (w_sel_exec[i]) r_state[i] <= EXECUTED;
            EXECUTED:     if (w_ret[i])      r_state[i] <= EMPTY;
            default:                         r_state[i] <= EMPTY;
          endcase
        end

        if (w_sel_a0[i] && w_a0_acc)      r_sns[i] <= r_cnt;
        else if (w_sel_a1[i] && w_a1_acc) r_sns[i] <= r_cnt + SNS_W'(w_a0_acc);
        else if (w_renorm && w_valid[i])  r_sns[i] <= r_sns[i] - w_min_sns;
      end
    end
  end

`ifdef REB_STATS_EN
  logic [31:0] r_retire_total, r_stomp_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_total <= '0;
      r_stomp_total  <= '0;
    end else begin
      r_retire_total <= r_retire_total + 32'(w_r0_acc) + 32'(w_r1_acc);
      r_stomp_total  <= r_stomp_total + 32'(count_ones(8'(stomp & w_valid)));
    end
  end

  assign retire_total = r_retire_total;
  assign stomp_total  = r_stomp_total;
`endif

endmodule

`default_nettype wire
